// File: rtl/bin_to_seg_pkg.sv
// Shared definitions for the binary-to-7-segment scanner: segment codes,
// converter state encoding and the digit-count helper used at elaboration.
package bin_to_seg_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Number of decimal digits needed to show 2^width-1.
  function automatic int min_digits(input int width);
    longint unsigned max_val;
    int n;
    max_val = (64'd1 << width) - 64'd1;
    n = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// One BCD nibble (plus blank request) to a 7-segment pattern, with
// selectable output polarity.
module bcd_seg_decoder
  import bin_to_seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_low;

  always_comb begin
    // NOTE: default assignment first so every path drives seg_low (no latch).
    seg_low = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg_low = SEG_0;
        4'd1:    seg_low = SEG_1;
        4'd2:    seg_low = SEG_2;
        4'd3:    seg_low = SEG_3;
        4'd4:    seg_low = SEG_4;
        4'd5:    seg_low = SEG_5;
        4'd6:    seg_low = SEG_6;
        4'd7:    seg_low = SEG_7;
        4'd8:    seg_low = SEG_8;
        4'd9:    seg_low = SEG_9;
        default: seg_low = SEG_BLANK;
      endcase
    end
  end

  assign seg = SEG_ACTIVE_LOW ? seg_low : ~seg_low;

endmodule

// File: rtl/bin_to_seg_scanner.sv
// Iterative double-dabble converter (one shift per clock) feeding a
// time-multiplexed, leading-zero-blanked 7-segment display scan.
module bin_to_seg_scanner
  import bin_to_seg_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int SCAN_DIV       = 50000,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     digit_sel
);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "bin_to_seg_scanner: WIDTH must be 4..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $fatal(1, "bin_to_seg_scanner: DIGITS too small for WIDTH");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $fatal(1, "bin_to_seg_scanner: SCAN_DIV must be >= 2");
  end

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? SEG_0 : ~SEG_0;

  conv_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] scratch_shifted;
  logic [CNT_W-1:0] count;

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  always_comb begin
    scratch_adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  assign scratch_shifted = {scratch_adj[BCD_W-2:0], shreg[WIDTH-1]};

  // The result is published on the last shift edge, so bcd_valid is high
  // exactly while the FSM sits in DONE and in_ready returns one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      shreg     <= '0;
      scratch   <= '0;
      count     <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            scratch  <= '0;
            count    <= CNT_W'(WIDTH);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_shifted;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          count   <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            bcd_out   <= scratch_shifted;
            bcd_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  logic [PRE_W-1:0] prescale;
  logic [IDX_W-1:0] digit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale  <= '0;
      digit_idx <= '0;
    end else if (prescale == PRE_W'(SCAN_DIV - 1)) begin
      prescale  <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // A digit above 0 is blank when it and every digit above it are zero.
  logic [DIGITS-1:0] blank;
  logic              zero_run;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run & (bcd_out[4*k +: 4] == 4'd0);
      blank[k] = BLANK_LZ & zero_run;
    end
  end

  logic [3:0] cur_nibble;
  logic       cur_blank;
  logic [6:0] cur_seg;

  assign cur_nibble = bcd_out[4*digit_idx +: 4];
  assign cur_blank  = blank[digit_idx];

  bcd_seg_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decoder (
    .nibble(cur_nibble),
    .blank (cur_blank),
    .seg   (cur_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out   <= SEG_RESET;
      digit_sel <= ~DIGITS'(1);
    end else begin
      seg_out   <= cur_seg;
      digit_sel <= ~(DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: tb/tb_bin_to_seg_scanner.sv
// Self-checking bench: three scanner instances (8-bit blanked, 8-bit
// unblanked, 16-bit) checked against an arithmetic decimal/segment model.
module tb_bin_to_seg_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid8;
  logic [7:0]  in_data8;
  logic        in_ready8, bcd_valid8, in_ready8n, bcd_valid8n;
  logic [11:0] bcd_out8, bcd_out8n;
  logic [6:0]  seg8, seg8n;
  logic [2:0]  sel8, sel8n;

  logic        in_valid16;
  logic [15:0] in_data16;
  logic        in_ready16, bcd_valid16;
  logic [19:0] bcd_out16;
  logic [6:0]  seg16;
  logic [4:0]  sel16;

  int errors = 0;
  int checks = 0;

  bin_to_seg_scanner #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .bcd_out(bcd_out8), .bcd_valid(bcd_valid8), .seg_out(seg8), .digit_sel(sel8));

  bin_to_seg_scanner #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_w8n (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8n), .in_data(in_data8),
    .bcd_out(bcd_out8n), .bcd_valid(bcd_valid8n), .seg_out(seg8n), .digit_sel(sel8n));

  bin_to_seg_scanner #(.WIDTH(16), .DIGITS(5), .SCAN_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_w16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .bcd_out(bcd_out16), .bcd_valid(bcd_valid16), .seg_out(seg16), .digit_sel(sel16));

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] bcd_model(input int unsigned v);
    logic [19:0] r = '0;
    for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  // Expected active-low pattern for digit d of value v; d<0 yields X.
  function automatic logic [6:0] seg_model(input int unsigned v, input int d, input bit blank_lz);
    if (d < 0) return 7'bx;
    if (blank_lz && d > 0 && v < pow10(d)) return 7'h7F;
    return seg_tab[(v / pow10(d)) % 10];
  endfunction

  function automatic int sel_index(input logic [4:0] sel, input int n);
    logic [4:0] on;
    on = ~sel & ((5'd1 << n) - 5'd1);
    for (int k = 0; k < n; k++) if (on == (5'd1 << k)) return k;
    return -1;
  endfunction

  task automatic convert8(input int unsigned v);
    int k;
    logic [19:0] exp;
    exp = bcd_model(v);
    in_valid8 = 1'b1;
    in_data8  = 8'(v);
    k = 0;
    while (!in_ready8 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (!in_ready8) begin
      errors++; $display("FAIL c8_ready_wait got in_ready=%b exp 1", in_ready8);
      in_valid8 = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    checks++;
    if (in_ready8 !== 1'b0) begin errors++; $display("FAIL c8_ready_drop got %b exp 0", in_ready8); end
    k = 0;
    while (!bcd_valid8 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k != 8) begin errors++; $display("FAIL c8_latency v=%0d got %0d exp 8", v, k); end
    checks++;
    if (bcd_out8 !== exp[11:0]) begin errors++; $display("FAIL c8_bcd v=%0d got %h exp %h", v, bcd_out8, exp[11:0]); end
    checks++;
    if (bcd_out8n !== exp[11:0]) begin errors++; $display("FAIL c8n_bcd v=%0d got %h exp %h", v, bcd_out8n, exp[11:0]); end
    @(negedge clk);
    checks++;
    if (bcd_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL c8_pulse got valid=%b ready=%b exp 0 1", bcd_valid8, in_ready8);
    end
    checks++;
    if (seg8 !== seg_model(v, sel_index({2'b00, sel8}, 3), 1'b1)) begin
      errors++; $display("FAIL c8_seg_update v=%0d sel=%b got %h exp %h", v, sel8, seg8,
                         seg_model(v, sel_index({2'b00, sel8}, 3), 1'b1));
    end
  endtask

  task automatic convert16(input int unsigned v);
    int k;
    logic [19:0] exp;
    exp = bcd_model(v);
    in_valid16 = 1'b1;
    in_data16  = 16'(v);
    k = 0;
    while (!in_ready16 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (!in_ready16) begin
      errors++; $display("FAIL c16_ready_wait got in_ready=%b exp 1", in_ready16);
      in_valid16 = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid16 = 1'b0;
    k = 0;
    while (!bcd_valid16 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (k != 16) begin errors++; $display("FAIL c16_latency v=%0d got %0d exp 16", v, k); end
    checks++;
    if (bcd_out16 !== exp) begin errors++; $display("FAIL c16_bcd v=%0d got %h exp %h", v, bcd_out16, exp); end
    @(negedge clk);
    checks++;
    if (bcd_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      errors++; $display("FAIL c16_pulse got valid=%b ready=%b exp 0 1", bcd_valid16, in_ready16);
    end
  endtask

  task automatic scan16(input int unsigned v);
    logic [4:0] seen = '0;
    int d;
    for (int i = 0; i < 20; i++) begin
      d = sel_index(sel16, 5);
      if (d >= 0) seen[d] = 1'b1;
      checks++;
      if (seg16 !== seg_model(v, d, 1'b1)) begin
        errors++; $display("FAIL scan16 v=%0d sel=%b got %h exp %h", v, sel16, seg16, seg_model(v, d, 1'b1));
      end
      @(negedge clk);
    end
    checks++;
    if (seen !== 5'h1F) begin errors++; $display("FAIL scan16_cover got %b exp 11111", seen); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0;
    in_valid16 = 1'b0; in_data16 = '0;
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || bcd_out8 !== 12'h000 || bcd_valid8 !== 1'b0 || sel8 !== 3'b110 || seg8 !== 7'h40) begin
      errors++; $display("FAIL reset8 got ready=%b bcd=%h valid=%b sel=%b seg=%h exp 1 000 0 110 40",
                         in_ready8, bcd_out8, bcd_valid8, sel8, seg8);
    end
    checks++;
    if (in_ready16 !== 1'b1 || bcd_out16 !== 20'h0 || bcd_valid16 !== 1'b0 || sel16 !== 5'b11110 || seg16 !== 7'h40) begin
      errors++; $display("FAIL reset16 got ready=%b bcd=%h valid=%b sel=%b seg=%h exp 1 00000 0 11110 40",
                         in_ready16, bcd_out16, bcd_valid16, sel16, seg16);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_order();
    logic [2:0] prev;
    logic [2:0] exp_sel;
    int k;
    convert8(7);
    prev = sel8;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (sel8 == 3'b110 && prev != 3'b110) break;
      prev = sel8;
    end while (k < 30);
    checks++;
    if (k >= 30) begin errors++; $display("FAIL frame_align got no digit-0 entry exp one within 30 cycles"); return; end
    for (int i = 0; i < 12; i++) begin
      exp_sel = ~(3'd1 << (i / 4));
      checks++;
      if (sel8 !== exp_sel || seg8 !== seg_model(7, i / 4, 1'b1)) begin
        errors++; $display("FAIL frame_blank cyc=%0d got sel=%b seg=%h exp %b %h", i, sel8, seg8, exp_sel,
                           seg_model(7, i / 4, 1'b1));
      end
      checks++;
      if (sel8n !== exp_sel || seg8n !== seg_model(7, i / 4, 1'b0)) begin
        errors++; $display("FAIL frame_noblank cyc=%0d got sel=%b seg=%h exp %b %h", i, sel8n, seg8n, exp_sel,
                           seg_model(7, i / 4, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wide();
    convert16(65535);
    scan16(65535);
    convert16(0);
    scan16(0);
    convert16(10000);
    scan16(10000);
  endtask

  task automatic test_random();
    int unsigned v;
    int unsigned edge8 [6] = '{0, 255, 9, 10, 99, 100};
    foreach (edge8[i]) convert8(edge8[i]);
    for (int i = 0; i < 8; i++) convert8($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 65535);
      convert16(v);
      if (i % 2 == 0) scan16(v);
    end
    convert16(9999);
  endtask

  task automatic test_back_to_back();
    int sent = 0, npulse = 0, hold = 4;
    int pulse_cyc [4];
    logic [11:0] pulse_val [4];
    logic [11:0] last_out;
    bit changed = 1'b0, acc;
    last_out  = bcd_out8;
    in_valid8 = 1'b1;
    in_data8  = 8'd10;
    for (int c = 0; c < 60; c++) begin
      acc = in_valid8 && in_ready8;
      @(negedge clk);
      if (bcd_valid8) begin
        if (npulse < 4) begin pulse_cyc[npulse] = c; pulse_val[npulse] = bcd_out8; end
        npulse++;
      end else if (bcd_out8 !== last_out) changed = 1'b1;
      last_out = bcd_out8;
      if (acc) begin
        sent++;
        if (sent == 1) in_data8 = 8'd200;
        if (sent == 2) in_data8 = 8'd77;
      end else if (sent == 2) begin
        if (hold > 0) hold--;
        else in_valid8 = 1'b0;
      end
    end
    in_valid8 = 1'b0;
    checks++;
    if (npulse != 2 || sent != 2) begin
      errors++; $display("FAIL b2b_count got pulses=%0d accepts=%0d exp 2 2", npulse, sent);
      return;
    end
    checks++;
    if (pulse_cyc[1] - pulse_cyc[0] != 10) begin
      errors++; $display("FAIL b2b_gap got %0d exp 10", pulse_cyc[1] - pulse_cyc[0]);
    end
    checks++;
    if (pulse_val[0] !== 12'h010 || pulse_val[1] !== 12'h200) begin
      errors++; $display("FAIL b2b_values got %h %h exp 010 200", pulse_val[0], pulse_val[1]);
    end
    checks++;
    if (changed) begin errors++; $display("FAIL b2b_busy_ignore got bcd_out change without bcd_valid exp none"); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    in_valid8 = 1'b1;
    in_data8  = 8'd99;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || bcd_out8 !== 12'h000 || bcd_valid8 !== 1'b0 || sel8 !== 3'b110 || seg8 !== 7'h40) begin
      errors++; $display("FAIL reset_mid got ready=%b bcd=%h valid=%b sel=%b seg=%h exp 1 000 0 110 40",
                         in_ready8, bcd_out8, bcd_valid8, sel8, seg8);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bcd_valid8) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_mid_no_valid got bcd_valid pulse exp none"); end
    convert8(42);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    convert8(255);
    test_frame_order();
    test_wide();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
